// File: rtl/if_stage_pkg.sv
// Shared fetch-pipeline definitions: redirect encodings, bubble word, fetch FSM states.
package if_stage_pkg;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;
  localparam logic [1:0] PC_SRC_JR  = 2'b11;

  localparam logic [31:0] NOP_INS_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    HOLD,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/if_stage_next_pc_sel.sv
// Redirect target mux: branch target, jump into current 256 MB region, or jr register.
module next_pc_sel
  import if_stage_pkg::*;
(
  input  logic [1:0]  i_pc_src,
  input  logic [31:0] i_branch,
  input  logic [27:0] i_offset28,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_pc_4,
  output logic [31:0] o_target
);

  always_comb begin
    case (i_pc_src)
      PC_SRC_BR: o_target = i_branch;
      PC_SRC_J:  o_target = {i_pc_4[31:28], i_offset28};
      PC_SRC_JR: o_target = i_rs;
      default:   o_target = i_pc_4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, single-outstanding imem handshake, IF/ID register.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = NOP_INS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch,
  input  logic [27:0] offset28,
  input  logic [31:0] rs,
  input  logic        if_flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_4_out,
  output logic [31:0] ins_out,
  output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_squash,
  output logic [31:0] perf_wait
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pc_tgt;
  logic [31:0]  r_hold_ins;
  logic [31:0]  r_ins;
  logic [31:0]  r_pc_4;
  logic         r_valid;

  logic         w_redir;
  logic         w_deliver;
  logic [31:0]  w_target;
  logic [31:0]  w_word;
  logic [31:0]  w_word_pc_4;

  // A held decode instruction has not made its final decision, so redirects wait.
  assign w_redir = if_flush & (pc_src != PC_SRC_SEQ) & ~stall;

  next_pc_sel u_next_pc_sel (
    .i_pc_src   (pc_src),
    .i_branch   (branch),
    .i_offset28 (offset28),
    .i_rs       (rs),
    .i_pc_4     (r_pc_4),
    .o_target   (w_target)
  );

  // In HOLD the PC has already advanced past the buffered word, so it is that word's PC+4.
  always_comb begin
    w_deliver   = 1'b0;
    w_word      = imem_rdata;
    w_word_pc_4 = r_pc + 32'd4;
    case (r_state)
      REQ:  w_deliver = imem_ready & ~stall & ~w_redir;
      HOLD: begin
        w_deliver   = ~stall & ~w_redir;
        w_word      = r_hold_ins;
        w_word_pc_4 = r_pc;
      end
      default: w_deliver = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= REQ;
      r_pc       <= RESET_PC;
      r_pc_tgt   <= RESET_PC;
      r_hold_ins <= NOP_INS;
      r_ins      <= NOP_INS;
      r_pc_4     <= 32'd0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        REQ: begin
          if (imem_ready) begin
            if (w_redir) begin
              r_pc <= w_target;
            end else begin
              r_pc <= r_pc + 32'd4;
              if (stall) begin
                r_hold_ins <= imem_rdata;
                r_state    <= HOLD;
              end
            end
          end else if (w_redir) begin
            r_pc_tgt <= w_target;
            r_state  <= DROP;
          end
        end
        HOLD: begin
          if (!stall) begin
            if (w_redir) r_pc <= w_target;
            r_state <= REQ;
          end
        end
        DROP: begin
          if (imem_ready) begin
            r_pc    <= w_redir ? w_target : r_pc_tgt;
            r_state <= REQ;
          end else if (w_redir) begin
            r_pc_tgt <= w_target;
          end
        end
        default: r_state <= REQ;
      endcase

      if (!stall) begin
        if (w_deliver) begin
          r_ins   <= w_word;
          r_pc_4  <= w_word_pc_4;
          r_valid <= 1'b1;
        end else begin
          r_ins   <= NOP_INS;
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req   = (r_state != HOLD);
  assign imem_addr  = r_pc;
  assign pc_4_out   = r_pc_4;
  assign ins_out    = r_ins;
  assign ifid_valid = r_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_squash;
  logic [31:0] r_perf_wait;
  logic        w_squash;
  logic        w_wait;

  assign w_squash = ((r_state == REQ)  & imem_ready & w_redir) |
                    ((r_state == HOLD) & ~stall & w_redir) |
                    ((r_state == DROP) & imem_ready);
  assign w_wait   = imem_req & ~imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetch  <= 32'd0;
      r_perf_squash <= 32'd0;
      r_perf_wait   <= 32'd0;
    end else begin
      if (w_deliver && r_perf_fetch != 32'hFFFF_FFFF) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_squash && r_perf_squash != 32'hFFFF_FFFF) r_perf_squash <= r_perf_squash + 32'd1;
      if (w_wait && r_perf_wait != 32'hFFFF_FFFF) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_fetch  = r_perf_fetch;
  assign perf_squash = r_perf_squash;
  assign perf_wait   = r_perf_wait;
`endif

endmodule
